// File: rtl/ball_control.sv
// rtl/ball_control.sv - ball step sequencer: erase, collide, move, redraw.
// Optional BALL_CTRL_SPEEDUP_EN shortens the frame divisor on each paddle hit.
module ball_control #(
  parameter int SCREEN_W        = 160,
  parameter int TOP_Y           = 34,
  parameter int BOTTOM_Y        = 119,
  parameter int BALL_SIZE       = 2,
  parameter int PADDLE_Y        = 112,
  parameter int PADDLE_W        = 16,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       plot_done,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic       h_q,
  input  logic       v_q,
  input  logic [7:0] paddle_x,
  output logic       reset_counts,
  output logic       en_counters,
  output logic       h_t,
  output logic       v_t,
  output logic       sel_c,
  output logic       plot,
  output logic       ball_lost,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_SERVE, S_WAIT, S_ERASE_REQ, S_ERASE_WAIT,
    S_CHECK, S_MOVE, S_DRAW_REQ, S_DRAW_WAIT, S_LOST
  } state_t;

  localparam int CW = (FRAMES_PER_STEP < 2) ? 1 : $clog2(FRAMES_PER_STEP + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div;
  logic [8:0]    x9, y9, px9;
  logic          hit_h, hit_top, hit_paddle, miss;

  // 9-bit operands so x+BALL_SIZE and paddle_x+PADDLE_W never wrap
  assign x9  = {1'b0, x};
  assign y9  = {2'b00, y};
  assign px9 = {1'b0, paddle_x};

  assign hit_h      = h_q ? (x9 + 9'(BALL_SIZE) >= 9'(SCREEN_W)) : (x9 == 9'd0);
  assign hit_top    = !v_q && (y9 <= 9'(TOP_Y));
  assign hit_paddle = v_q && (y9 + 9'(BALL_SIZE) == 9'(PADDLE_Y)) &&
                      (x9 + 9'(BALL_SIZE) > px9) && (x9 < px9 + 9'(PADDLE_W));
  assign miss       = v_q && (y9 + 9'(BALL_SIZE) > 9'(BOTTOM_Y)) && !hit_paddle;

`ifdef BALL_CTRL_SPEEDUP_EN
  logic [CW-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (state_q == S_SERVE) begin
      div_d = CW'(FRAMES_PER_STEP);
    end else if (state_q == S_CHECK && hit_paddle && div_q > CW'(1)) begin
      div_d = div_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= CW'(FRAMES_PER_STEP);
    end else begin
      div_q <= div_d;
    end
  end

  assign div = div_q;
`else
  assign div = CW'(FRAMES_PER_STEP);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    reset_counts = 1'b1;
    en_counters  = 1'b0;
    h_t          = 1'b0;
    v_t          = 1'b0;
    sel_c        = 1'b0;
    plot         = 1'b0;
    ball_lost    = 1'b0;
    busy         = 1'b0;
    case (state_q)
      S_IDLE: begin
        reset_counts = 1'b0;
        cnt_d        = '0;
        if (start) state_d = S_SERVE;
      end
      S_SERVE: begin
        reset_counts = 1'b0;
        cnt_d        = '0;
        state_d      = S_DRAW_REQ;
      end
      S_WAIT: begin
        if (frame_tick) begin
          if (cnt_q + CW'(1) >= div) begin
            cnt_d   = '0;
            state_d = S_ERASE_REQ;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_ERASE_REQ: begin
        busy    = 1'b1;
        plot    = 1'b1;
        state_d = S_ERASE_WAIT;
      end
      S_ERASE_WAIT: begin
        busy = 1'b1;
        if (plot_done) state_d = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (miss) begin
          state_d = S_LOST;
        end else begin
          h_t     = hit_h;
          v_t     = hit_top | hit_paddle;
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        busy        = 1'b1;
        en_counters = 1'b1;
        state_d     = S_DRAW_REQ;
      end
      S_DRAW_REQ: begin
        busy    = 1'b1;
        plot    = 1'b1;
        sel_c   = 1'b1;
        state_d = S_DRAW_WAIT;
      end
      S_DRAW_WAIT: begin
        busy  = 1'b1;
        sel_c = 1'b1;
        if (plot_done) state_d = S_WAIT;
      end
      S_LOST: begin
        ball_lost = 1'b1;
        if (start) state_d = S_SERVE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/ball_control.md
Name: ball_control

Overview:
- FSM controller that sequences the ball-movement datapath once per game step: erase old ball, resolve wall/paddle collisions, advance the counters, redraw.
- Drives the datapath's counter reset, counter enable, direction toggles and colour select.
- Handshakes with the ball display block through plot/plot_done.
- Sits between the frame-tick generator, paddle logic and the ball datapath/display.

Parameters:
- SCREEN_W, 160, playfield width in pixels; x range 0..SCREEN_W-1.
- TOP_Y, 34, lowest legal ball y (top wall); also the datapath's serve row.
- BOTTOM_Y, 119, last playfield row.
- BALL_SIZE, 2, ball edge length in pixels.
- PADDLE_Y, 112, paddle top row.
- PADDLE_W, 16, paddle width in pixels.
- FRAMES_PER_STEP, 2, frame_tick pulses per ball step (>=1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  serve request (level; sampled in IDLE/LOST)
- frame_tick  in  1  one-cycle pulse per video frame
- plot_done  in  1  one-cycle pulse from display when the draw/erase finishes
- x  in  8  ball top-left x from datapath
- y  in  7  ball top-left y from datapath
- h_q  in  1  datapath horizontal direction (1 = right)
- v_q  in  1  datapath vertical direction (1 = down)
- paddle_x  in  8  paddle left x
- reset_counts  out  1  active-low datapath counter/direction reset
- en_counters  out  1  datapath step enable
- h_t  out  1  horizontal toggle pulse
- v_t  out  1  vertical toggle pulse
- sel_c  out  1  1 = ball colour, 0 = background
- plot  out  1  one-cycle display start pulse
- ball_lost  out  1  high while in LOST
- busy  out  1  high in ERASE..DRAW

Behaviour:
- Reset: state=IDLE. reset_counts=0; en_counters, h_t, v_t, sel_c, plot, ball_lost, busy=0. Frame count=0.
- IDLE: reset_counts held 0. start=1 -> SERVE.
- SERVE (1 cycle): reset_counts=0, then -> DRAW_REQ so the ball appears before it moves.
- WAIT: reset_counts=1. Count frame_tick; when the count reaches the step divisor: clear the count, -> ERASE_REQ. frame_tick outside WAIT is dropped.
- ERASE_REQ: plot=1, sel_c=0 for 1 cycle -> ERASE_WAIT.
- ERASE_WAIT: sel_c=0; on plot_done -> CHECK.
- CHECK (1 cycle): h_t/v_t asserted per the collision rules below -> MOVE, or -> LOST.
- MOVE (1 cycle): en_counters=1 -> DRAW_REQ. The toggles have registered by now, so the step uses the new direction.
- DRAW_REQ: plot=1, sel_c=1 for 1 cycle -> DRAW_WAIT.
- DRAW_WAIT: sel_c=1; on plot_done -> WAIT.
- LOST: ball_lost=1, counters frozen. start=1 -> SERVE.
- Collision rules (evaluated in CHECK, using 9-bit arithmetic, no wrap):
  - h_t=1 if h_q=1 and x+BALL_SIZE >= SCREEN_W.
  - h_t=1 if h_q=0 and x==0.
  - v_t=1 if v_q=0 and y <= TOP_Y.
  - v_t=1 (paddle hit) if v_q=1, y+BALL_SIZE == PADDLE_Y, x+BALL_SIZE > paddle_x, and x < paddle_x+PADDLE_W.
  - Lost if v_q=1, y+BALL_SIZE > BOTTOM_Y, and no paddle hit: no toggles, no MOVE, -> LOST.
  - Corner hit: h_t and v_t asserted in the same cycle.
- plot_done arriving while not in a *_WAIT state is ignored.
- Latency: frame_tick to plot = 1 cycle. plot_done(erase) to en_counters = 2 cycles.
- Reset mid-frame: returns to IDLE immediately. Any draw in progress in the display is abandoned; the display block must tolerate this.

Optional Feature:
- Macro: BALL_CTRL_SPEEDUP_EN.
- Defined: step divisor register loaded with FRAMES_PER_STEP in SERVE; decremented by 1 on each paddle hit, floor 1.
- Undefined: divisor fixed at FRAMES_PER_STEP, and no divisor register is synthesized.

Test Plan:
- Reset then start=1 -> reset_counts low exactly 1 cycle, plot with sel_c=1; busy=0 after plot_done.
- FRAMES_PER_STEP=2: 2 frame_tick pulses -> erase plot (sel_c=0) 1 cycle after the 2nd tick; en_counters 1 pulse only after erase plot_done.
- x=158, h_q=1, y=60 -> h_t=1, v_t=0 in CHECK; en_counters on the following cycle.
- x=0, h_q=0, y=34, v_q=0 -> h_t=1 and v_t=1 in the same cycle.
- v_q=1, y=110, paddle_x=40, x=50 -> v_t=1. Same with paddle_x=100 -> no toggle; the ball continues down.
- y=118, v_q=1, paddle missed -> LOST, ball_lost=1, en_counters never pulses. start=1 -> SERVE. With BALL_CTRL_SPEEDUP_EN: 2 paddle hits take the divisor 2->1->1.
